hdmi_tmng_gen: RTL and testbench
================================

Name: hdmi_tmng_gen

Overview:
- Video timing generator for the ADV7513 controller, downstream of the pixel line buffer's FWFT FIFO read port, in the HDMI pixel clock domain.
- Produces HSYNC/VSYNC/DE and 24-bit pixel data for 1280x720 frames.
- Pops exactly one FIFO word per active pixel.
- Gates active video on a FIFO prefill and flags underflow.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (clocks)
- H_SYNC, 40, hsync width (clocks)
- H_BP, 220, horizontal back porch (clocks)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- HSYNC_POL, 1, asserted level of vid_hsync
- VSYNC_POL, 1, asserted level of vid_vsync
- PREFILL_CYCLES, 64, consecutive non-empty cycles required before video starts
- UNDRFLW_COLOR, 24'hFF0000, pixel driven on underflow

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset
- tmng_en  in  1  block enable (same source as line buffer enable, synchronised)
- ff_empty  in  1  FIFO empty
- ff_rdata  in  24  FIFO head data, FWFT
- ff_rd_en  out  1  FIFO pop
- vid_hsync  out  1  horizontal sync
- vid_vsync  out  1  vertical sync
- vid_de  out  1  data enable
- vid_data  out  24  pixel {R,G,B}
- frame_start  out  1  one-cycle pulse, first active pixel of a frame
- undrflw  out  1  sticky underflow flag
- undrflw_cnt  out  16  underflowed pixel count, saturating
- tmng_active  out  1  high in ACTIVE state

Behaviour:
- Reset: everything is reset asynchronously on rst_n low.
  - Counters are 0, state is IDLE.
  - All outputs are 0, except syncs, which sit at the deasserted level (~POL).
- Totals: H_TOTAL = sum of the H_* parameters (1650); V_TOTAL = sum of the V_* parameters (750).
- Counters:
  - h_cntr runs 0..H_TOTAL-1 and wraps.
  - v_cntr increments on h wrap, runs 0..V_TOTAL-1 and wraps.
  - Widths are $clog2(total).
- Regions:
  - Active when h < H_ACTIVE and v < V_ACTIVE.
  - hsync asserted when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted for whole lines V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
- FSM:
  - IDLE:
    - Counters are held at h=0, v=V_ACTIVE.
    - Outputs are inactive; ff_rd_en=0.
    - Goes to PREFILL when tmng_en=1.
  - PREFILL:
    - Counters run and blanking syncs are emitted.
    - prefill_cntr increments while ~ff_empty and clears when ff_empty.
    - Goes to ACTIVE at the frame wrap (h=H_TOTAL-1, v=V_TOTAL-1) only if prefill_cntr >= PREFILL_CYCLES; otherwise it stays in PREFILL for another blank frame.
    - No FIFO reads.
  - ACTIVE:
    - ff_rd_en = active_region & ~ff_empty (combinational).
    - Data is captured from ff_rdata in the same cycle.
  - tmng_en=0 in any state goes to IDLE on the next clock. Outputs are deasserted on that clock; a partial line is abandoned.
- Output latency:
  - syncs, de, vid_data and frame_start are registered, one clock after the counter values that produce them.
  - All video outputs are mutually aligned.
- vid_data:
  - ff_rdata on an active pixel with a pop.
  - UNDRFLW_COLOR on an active pixel with ff_empty in ACTIVE.
  - 0 during blanking and in PREFILL.
- vid_de is 1 for every active pixel in ACTIVE, including underflowed pixels, so the raster is never broken.
- Underflow:
  - undrflw is set on active & ff_empty in ACTIVE and cleared only by reset or IDLE.
  - undrflw_cnt increments on the same condition, saturates at 16'hFFFF, and clears in IDLE.
  - The state stays ACTIVE; pixel misalignment persists until tmng_en is toggled.
- frame_start is registered with the h=0, v=0 pixel in ACTIVE.
- Pops: exactly H_ACTIVE*V_ACTIVE (921600) per underflow-free frame.

Optional Feature:
- Macro HDMI_TMNG_GEN_TPG_EN adds input port tpg_en (1 bit).
- With the macro, tpg_en=1 in ACTIVE selects a test pattern:
  - Eight vertical colour bars, bar index = h_cntr*8/H_ACTIVE, colours white, yellow, cyan, green, magenta, red, blue, black.
  - ff_rd_en=0, no underflow counting.
  - Timing is unchanged.
  - PREFILL is bypassed: ACTIVE is entered at the next frame wrap regardless of FIFO state.
- Without the macro there is no tpg_en port and no pattern logic.

Decomposition:
- Package hdmi_tmng_pkg holds:
  - the 720p timing localparams and derived H_TOTAL/V_TOTAL;
  - the tmng_fsm_t enum {IDLE, PREFILL, ACTIVE};
  - the colour-bar constant array.
- Sub-module hdmi_hv_cntr: h/v counters with hold/load-to-blank input, plus region decode (active, hsync_raw, vsync_raw, frame_wrap).

Test Plan:
- Reset and enable with an always-non-empty FIFO model:
  - First ACTIVE frame begins after exactly one blank frame.
  - hsync is 40 clocks every 1650; vsync is 5 lines.
  - de is high for 1280 clocks x 720 lines; 921600 pops per frame; undrflw=0.
- FIFO model with incrementing data:
  - vid_data follows ff_rdata with 1-clock latency, aligned with de.
  - frame_start coincides with the first de of each frame.
- Prefill gating: ff_empty toggles every 40 clocks during PREFILL, so the count never reaches 64, and the state stays PREFILL across 3 frames. Then hold non-empty → ACTIVE at the next wrap.
- Force ff_empty for 10 active pixels mid-line in ACTIVE:
  - vid_data = FF0000 for 10 clocks, de is still high, no pops on those cycles.
  - undrflw=1, undrflw_cnt=10.
- Deassert tmng_en at h=500, v=300:
  - Next clock: de=0, ff_rd_en=0, syncs inactive, state IDLE, undrflw_cnt cleared.
  - Re-enable → PREFILL → full frame again.
- TPG build with tpg_en=1: no pops and no underflow counted with FIFO empty; pixel 0 = FFFFFF, pixel 160 = FFFF00, pixel 1279 = 000000.

Source files
------------

// File: rtl/hdmi_tmng_pkg.sv
// Shared 720p timing constants, FSM state type and test-pattern colours for the HDMI timing generator.
// The optional colour-bar generator is enabled by defining HDMI_TMNG_GEN_TPG_EN.
package hdmi_tmng_pkg;

  localparam int unsigned H_ACTIVE_720 = 1280;
  localparam int unsigned H_FP_720     = 110;
  localparam int unsigned H_SYNC_720   = 40;
  localparam int unsigned H_BP_720     = 220;
  localparam int unsigned V_ACTIVE_720 = 720;
  localparam int unsigned V_FP_720     = 5;
  localparam int unsigned V_SYNC_720   = 5;
  localparam int unsigned V_BP_720     = 20;

  localparam int unsigned H_TOTAL_720 = H_ACTIVE_720 + H_FP_720 + H_SYNC_720 + H_BP_720;
  localparam int unsigned V_TOTAL_720 = V_ACTIVE_720 + V_FP_720 + V_SYNC_720 + V_BP_720;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREFILL = 2'd1,
    ACTIVE  = 2'd2
  } tmng_fsm_t;

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][23:0] BAR_COLORS = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

endpackage

// File: rtl/hdmi_hv_cntr.sv
// Horizontal/vertical raster counters with a load-to-blank input, plus region decode.
// Loading parks the raster at the start of vertical blanking (h=0, v=V_ACTIVE).
module hdmi_hv_cntr
  import hdmi_tmng_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_720,
  parameter int unsigned H_FP     = H_FP_720,
  parameter int unsigned H_SYNC   = H_SYNC_720,
  parameter int unsigned H_BP     = H_BP_720,
  parameter int unsigned V_ACTIVE = V_ACTIVE_720,
  parameter int unsigned V_FP     = V_FP_720,
  parameter int unsigned V_SYNC   = V_SYNC_720,
  parameter int unsigned V_BP     = V_BP_720,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned HW      = $clog2(H_TOTAL),
  localparam int unsigned VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          blank_load,
  output logic [HW-1:0] h_cntr,
  output logic [VW-1:0] v_cntr,
  output logic          act_region,
  output logic          hsync_raw,
  output logic          vsync_raw,
  output logic          frame_wrap
);

  logic h_wrap;
  logic v_wrap;

  assign h_wrap     = (h_cntr == HW'(H_TOTAL - 1));
  assign v_wrap     = (v_cntr == VW'(V_TOTAL - 1));
  assign frame_wrap = h_wrap & v_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cntr <= '0;
      v_cntr <= '0;
    end else if (blank_load) begin
      h_cntr <= '0;
      v_cntr <= VW'(V_ACTIVE);
    end else if (h_wrap) begin
      h_cntr <= '0;
      v_cntr <= v_wrap ? '0 : v_cntr + VW'(1);
    end else begin
      h_cntr <= h_cntr + HW'(1);
    end
  end

  // Compare in 32 bits so region bounds equal to a power of two cannot truncate.
  always_comb begin
    act_region = (32'(h_cntr) < H_ACTIVE) && (32'(v_cntr) < V_ACTIVE);
    hsync_raw  = (32'(h_cntr) >= H_ACTIVE + H_FP) && (32'(h_cntr) < H_ACTIVE + H_FP + H_SYNC);
    vsync_raw  = (32'(v_cntr) >= V_ACTIVE + V_FP) && (32'(v_cntr) < V_ACTIVE + V_FP + V_SYNC);
  end

endmodule

// File: rtl/hdmi_tmng_gen.sv
// Video timing generator feeding the ADV7513 from a FWFT line-buffer FIFO, one pop per active pixel.
// Define HDMI_TMNG_GEN_TPG_EN to add the tpg_en input and the colour-bar test pattern.
module hdmi_tmng_gen
  import hdmi_tmng_pkg::*;
#(
  parameter int unsigned H_ACTIVE       = H_ACTIVE_720,
  parameter int unsigned H_FP           = H_FP_720,
  parameter int unsigned H_SYNC         = H_SYNC_720,
  parameter int unsigned H_BP           = H_BP_720,
  parameter int unsigned V_ACTIVE       = V_ACTIVE_720,
  parameter int unsigned V_FP           = V_FP_720,
  parameter int unsigned V_SYNC         = V_SYNC_720,
  parameter int unsigned V_BP           = V_BP_720,
  parameter bit          HSYNC_POL      = 1'b1,
  parameter bit          VSYNC_POL      = 1'b1,
  parameter int unsigned PREFILL_CYCLES = 64,
  parameter logic [23:0] UNDRFLW_COLOR  = 24'hFF0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tmng_en,
`ifdef HDMI_TMNG_GEN_TPG_EN
  input  logic        tpg_en,
`endif
  input  logic        ff_empty,
  input  logic [23:0] ff_rdata,
  output logic        ff_rd_en,
  output logic        vid_hsync,
  output logic        vid_vsync,
  output logic        vid_de,
  output logic [23:0] vid_data,
  output logic        frame_start,
  output logic        undrflw,
  output logic [15:0] undrflw_cnt,
  output logic        tmng_active
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned PW      = $clog2(PREFILL_CYCLES + 1);

  tmng_fsm_t     state_q, state_d;
  logic [PW-1:0] prefill_cntr_q, prefill_cntr_d;
  logic [HW-1:0] h_cntr;
  logic [VW-1:0] v_cntr;
  logic          act_region, hsync_raw, vsync_raw, frame_wrap;
  logic          blank_load, prefill_done, pix_act, pix_undrflw, tpg_on;
  logic [23:0]   pix_data;

  logic          hsync_q, vsync_q, de_q, frame_start_q, undrflw_q;
  logic [23:0]   data_q;
  logic [15:0]   undrflw_cnt_q;

  // Disabling, or sitting in IDLE, parks the raster and clears the underflow record.
  assign blank_load   = ~tmng_en | (state_q == IDLE);
  assign pix_act      = tmng_en & (state_q == ACTIVE) & act_region;
  assign prefill_done = (prefill_cntr_q >= PW'(PREFILL_CYCLES));

  hdmi_hv_cntr #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_hv_cntr (
    .clk        (clk),
    .rst_n      (rst_n),
    .blank_load (blank_load),
    .h_cntr     (h_cntr),
    .v_cntr     (v_cntr),
    .act_region (act_region),
    .hsync_raw  (hsync_raw),
    .vsync_raw  (vsync_raw),
    .frame_wrap (frame_wrap)
  );

`ifdef HDMI_TMNG_GEN_TPG_EN
  logic [2:0] bar_idx;

  assign tpg_on  = tpg_en;
  assign bar_idx = 3'((32'(h_cntr) << 3) / H_ACTIVE);

  always_comb begin
    pix_data = ff_empty ? UNDRFLW_COLOR : ff_rdata;
    if (tpg_en) begin
      pix_data = BAR_COLORS[bar_idx];
    end
  end
`else
  assign tpg_on   = 1'b0;
  assign pix_data = ff_empty ? UNDRFLW_COLOR : ff_rdata;
`endif

  // Pixels keep DE even when the FIFO runs dry so the sink never sees a broken raster.
  assign ff_rd_en    = pix_act & ~ff_empty & ~tpg_on;
  assign pix_undrflw = pix_act & ff_empty & ~tpg_on;

  always_comb begin
    state_d = state_q;
    if (!tmng_en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = PREFILL;
        PREFILL: begin
          if (frame_wrap && (prefill_done || tpg_on)) begin
            state_d = ACTIVE;
          end
        end
        ACTIVE:  state_d = ACTIVE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Counts consecutive non-empty cycles, saturating once the prefill target is met.
  always_comb begin
    prefill_cntr_d = '0;
    if (tmng_en && (state_q == PREFILL) && !ff_empty) begin
      prefill_cntr_d = prefill_done ? prefill_cntr_q : prefill_cntr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      prefill_cntr_q <= '0;
      hsync_q        <= ~HSYNC_POL;
      vsync_q        <= ~VSYNC_POL;
      de_q           <= 1'b0;
      data_q         <= '0;
      frame_start_q  <= 1'b0;
      undrflw_q      <= 1'b0;
      undrflw_cnt_q  <= '0;
    end else begin
      state_q        <= state_d;
      prefill_cntr_q <= prefill_cntr_d;
      hsync_q        <= (~blank_load & hsync_raw) ? HSYNC_POL : ~HSYNC_POL;
      vsync_q        <= (~blank_load & vsync_raw) ? VSYNC_POL : ~VSYNC_POL;
      de_q           <= pix_act;
      data_q         <= pix_act ? pix_data : '0;
      frame_start_q  <= pix_act & (h_cntr == '0) & (v_cntr == '0);
      if (blank_load) begin
        undrflw_q     <= 1'b0;
        undrflw_cnt_q <= '0;
      end else if (pix_undrflw) begin
        undrflw_q <= 1'b1;
        if (undrflw_cnt_q != 16'hFFFF) begin
          undrflw_cnt_q <= undrflw_cnt_q + 16'd1;
        end
      end
    end
  end

  assign vid_hsync   = hsync_q;
  assign vid_vsync   = vsync_q;
  assign vid_de      = de_q;
  assign vid_data    = data_q;
  assign frame_start = frame_start_q;
  assign undrflw     = undrflw_q;
  assign undrflw_cnt = undrflw_cnt_q;
  assign tmng_active = (state_q == ACTIVE);

endmodule

// File: tb/tb_hdmi_tmng_gen.sv
// Bench for hdmi_tmng_gen on a shrunken raster; a per-cycle raster model predicts every output.
// With HDMI_TMNG_GEN_TPG_EN defined the colour-bar path is exercised as well.
module tb_hdmi_tmng_gen;

  localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 6, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam int PF = 64;
  localparam logic [23:0] RED = 24'hFF0000;
  localparam int M_IDLE = 0, M_PRE = 1, M_ACT = 2;

  logic        clk = 1'b0;
  logic        rst_n, tmng_en, ff_empty, ff_rd_en;
  logic        vid_hsync, vid_vsync, vid_de, frame_start, undrflw, tmng_active;
  logic [23:0] ff_rdata, vid_data;
  logic [15:0] undrflw_cnt;
  logic        tpg_en = 1'b0;

  always #5 clk = ~clk;

  hdmi_tmng_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PREFILL_CYCLES(PF), .UNDRFLW_COLOR(RED)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tmng_en     (tmng_en),
`ifdef HDMI_TMNG_GEN_TPG_EN
    .tpg_en      (tpg_en),
`endif
    .ff_empty    (ff_empty),
    .ff_rdata    (ff_rdata),
    .ff_rd_en    (ff_rd_en),
    .vid_hsync   (vid_hsync),
    .vid_vsync   (vid_vsync),
    .vid_de      (vid_de),
    .vid_data    (vid_data),
    .frame_start (frame_start),
    .undrflw     (undrflw),
    .undrflw_cnt (undrflw_cnt),
    .tmng_active (tmng_active)
  );

  int checks = 0;
  int errors = 0;

  // Raster model: mode, linear position within the frame, prefill run length, underflow record.
  int          m_mode, m_t, m_pcnt, m_ucnt;
  bit          m_uf;
  logic [23:0] fifo_head;
  bit          rand_data, last_pop;
  bit          e_hs, e_vs, e_de, e_fs, e_act;
  logic [23:0] e_data;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] bar_color(input int h);
    case ((h * 8) / HA)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic tick(input bit en, input bit emp);
    int h, v, nmode;
    bit act, live, pix, tpg;
    tmng_en  = en;
    ff_empty = emp;
    ff_rdata = fifo_head;
    #1;
    h    = m_t % HT;
    v    = m_t / HT;
    act  = (h < HA) && (v < VA);
    live = en && (m_mode != M_IDLE);
    pix  = en && (m_mode == M_ACT) && act;
    tpg  = tpg_en;
    chk("ff_rd_en", ff_rd_en, pix && !emp && !tpg);
    last_pop = ff_rd_en;
    e_de   = pix;
    e_data = !pix ? 24'h0 : tpg ? bar_color(h) : emp ? RED : fifo_head;
    e_hs   = live && (h >= HA + HFP) && (h < HA + HFP + HS);
    e_vs   = live && (v >= VA + VFP) && (v < VA + VFP + VS);
    e_fs   = pix && (m_t == 0);
    if (!live) begin
      m_uf = 0; m_ucnt = 0;
    end else if (pix && emp && !tpg) begin
      m_uf = 1;
      if (m_ucnt < 65535) m_ucnt++;
    end
    nmode = m_mode;
    if (!en) nmode = M_IDLE;
    else if (m_mode == M_IDLE) nmode = M_PRE;
    else if (m_mode == M_PRE && m_t == FT - 1 && (m_pcnt >= PF || tpg)) nmode = M_ACT;
    m_pcnt = (en && m_mode == M_PRE && !emp) ? m_pcnt + 1 : 0;
    m_t    = live ? (m_t + 1) % FT : VA * HT;
    m_mode = nmode;
    e_act  = (m_mode == M_ACT);
    @(posedge clk);
    #1;
    if (last_pop) fifo_head = rand_data ? 24'($urandom) : fifo_head + 24'd1;
    chk("vid_hsync", vid_hsync, e_hs);
    chk("vid_vsync", vid_vsync, e_vs);
    chk("vid_de", vid_de, e_de);
    chk("vid_data", vid_data, e_data);
    chk("frame_start", frame_start, e_fs);
    chk("undrflw", undrflw, m_uf);
    chk("undrflw_cnt", undrflw_cnt, m_ucnt);
    chk("tmng_active", tmng_active, e_act);
  endtask

  // Runs enabled until the model sits at position tgt in ACTIVE; n is the number of ticks spent.
  task automatic wait_pos(input int tgt, input int bound, input bit emp, output int n);
    bit ok = 0;
    n = 0;
    while (n < bound && !ok) begin
      if (m_mode == M_ACT && m_t == tgt) ok = 1;
      else begin
        tick(1'b1, emp);
        n++;
      end
    end
    if (!ok) ok = (m_mode == M_ACT && m_t == tgt);
    chk("wait_pos_reached", ok, 1'b1);
  endtask

  typedef struct {
    bit en; bit emp; int reps; bit act; bit hs; bit vs; bit de;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int n, pops, des, hss, vss, fss;
    bit saw;
    logic [23:0] first_word;

    tbl[0] = '{1'b0, 1'b0, 2,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 18, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 2,  1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 3,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0; tmng_en = 1'b0; ff_empty = 1'b1; ff_rdata = '0;
    fifo_head = 24'h000001; rand_data = 0;
    m_mode = M_IDLE; m_t = 0; m_pcnt = 0; m_ucnt = 0; m_uf = 0;
    #23;
    chk("rst_hsync", vid_hsync, 1'b0);
    chk("rst_vsync", vid_vsync, 1'b0);
    chk("rst_de", vid_de, 1'b0);
    chk("rst_data", vid_data, 24'h0);
    chk("rst_frame_start", frame_start, 1'b0);
    chk("rst_undrflw", undrflw, 1'b0);
    chk("rst_undrflw_cnt", undrflw_cnt, 16'h0);
    chk("rst_tmng_active", tmng_active, 1'b0);
    chk("rst_ff_rd_en", ff_rd_en, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Idle, enable, then blanking syncs through the first PREFILL lines.
    for (int i = 0; i < 7; i++) begin
      for (int r = 0; r < tbl[i].reps; r++) tick(tbl[i].en, tbl[i].emp);
      chk("tbl_active", tmng_active, tbl[i].act);
      chk("tbl_hsync", vid_hsync, tbl[i].hs);
      chk("tbl_vsync", vid_vsync, tbl[i].vs);
      chk("tbl_de", vid_de, tbl[i].de);
    end

    // Always non-empty: ACTIVE starts at the first frame wrap after enabling.
    wait_pos(0, 2 * FT, 1'b0, n);
    chk("one_blank_frame", n, FT - VA * HT - 25);
    pops = 0; des = 0; hss = 0; vss = 0; fss = 0;
    for (int i = 0; i < FT; i++) begin
      first_word = fifo_head;
      tick(1'b1, 1'b0);
      if (i == 0) begin
        chk("first_frame_start", frame_start, 1'b1);
        chk("first_de", vid_de, 1'b1);
        chk("first_data", vid_data, first_word);
      end
      pops += int'(last_pop); des += int'(vid_de);
      hss += int'(vid_hsync); vss += int'(vid_vsync); fss += int'(frame_start);
    end
    chk("frame_pops", pops, HA * VA);
    chk("frame_de", des, HA * VA);
    chk("frame_hsync", hss, HS * VT);
    chk("frame_vsync", vss, VS * HT);
    chk("frame_fs", fss, 1);
    chk("frame_undrflw", undrflw, 1'b0);

    // Random FIFO occupancy and data against the model.
    rand_data = 1;
    for (int i = 0; i < 2 * FT; i++) tick(1'b1, $urandom_range(0, 9) == 0);
    rand_data = 0;

    // Prefill gating: 40-cycle non-empty runs never satisfy the 64-cycle prefill.
    tick(1'b0, 1'b0);
    saw = 0;
    for (int i = 0; i < 3 * FT; i++) begin
      tick(1'b1, ((i / 40) % 2) == 1);
      saw |= tmng_active;
    end
    chk("prefill_hold", saw, 1'b0);
    n = 0;
    while (!tmng_active && n < 2 * FT + 1) begin
      tick(1'b1, 1'b0);
      n++;
    end
    chk("prefill_release", tmng_active, 1'b1);

    // Ten underflowed pixels mid-line.
    wait_pos(2 * HT + 4, 2 * FT, 1'b0, n);
    for (int k = 0; k < 10; k++) begin
      tick(1'b1, 1'b1);
      chk("uf_data", vid_data, RED);
      chk("uf_de", vid_de, 1'b1);
      chk("uf_pop", last_pop, 1'b0);
    end
    chk("uf_flag", undrflw, 1'b1);
    chk("uf_cnt", undrflw_cnt, 16'd10);

    // Disable mid-frame; everything drops on the next clock.
    wait_pos(3 * HT + 5, 2 * FT, 1'b0, n);
    tick(1'b0, 1'b0);
    chk("dis_de", vid_de, 1'b0);
    chk("dis_rd_en", ff_rd_en, 1'b0);
    chk("dis_hsync", vid_hsync, 1'b0);
    chk("dis_vsync", vid_vsync, 1'b0);
    chk("dis_active", tmng_active, 1'b0);
    chk("dis_undrflw", undrflw, 1'b0);
    chk("dis_undrflw_cnt", undrflw_cnt, 16'd0);

    // Re-enable and collect one full frame.
    n = 0; saw = 0;
    while (!saw && n < 3 * FT) begin
      tick(1'b1, 1'b0);
      saw = frame_start;
      n++;
    end
    chk("reen_frame_start", saw, 1'b1);
    des = 1;
    for (int i = 1; i < FT; i++) begin
      tick(1'b1, 1'b0);
      des += int'(vid_de);
    end
    chk("reen_frame_de", des, HA * VA);

`ifdef HDMI_TMNG_GEN_TPG_EN
    // Colour bars with an empty FIFO: prefill bypassed, no pops, no underflow.
    tick(1'b0, 1'b1);
    tpg_en = 1'b1;
    wait_pos(0, 3 * FT, 1'b1, n);
    pops = 0;
    for (int i = 0; i < FT; i++) begin
      tick(1'b1, 1'b1);
      if (i == 0) chk("tpg_pix0", vid_data, 24'hFFFFFF);
      if (i == 2) chk("tpg_bar1", vid_data, 24'hFFFF00);
      if (i == HA - 1) chk("tpg_last", vid_data, 24'h000000);
      pops += int'(last_pop);
    end
    chk("tpg_pops", pops, 0);
    chk("tpg_undrflw", undrflw, 1'b0);
    chk("tpg_undrflw_cnt", undrflw_cnt, 16'd0);
    tpg_en = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
